// File: rtl/mem_stage_pipe.sv
// LEGv8 MEM pipeline stage. Data memory with configurable access latency,
// sub-word loads and stores with sign/zero extension, and misalignment suppression.
// A multi-cycle access holds the upstream stage through a combinational stall while
// it runs, then produces a registered MEM/WB bundle with a one-cycle out_valid pulse.
module mem_stage_pipe #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] ALUResultout,
    output logic [REG_W-1:0]  WriteRegout,
    output logic              RegWriteout,
    output logic              MemtoRegout,
    output logic              misalign
);

    localparam int unsigned ADDR_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned NUM_BYTES = DATA_W / 8;
    localparam int unsigned CNT_W     = $clog2(MEM_LATENCY + 1);
    localparam int unsigned LAST_CNT  = MEM_LATENCY - 1;
    localparam bit          MULTI_CYC = (MEM_LATENCY > 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Request copies held while a multi-cycle access runs
    logic              req_write_q, req_write_d;
    logic              req_read_q, req_read_d;
    logic              req_regwrite_q, req_regwrite_d;
    logic              req_memtoreg_q, req_memtoreg_d;
    logic [1:0]        req_size_q, req_size_d;
    logic              req_signed_q, req_signed_d;
    logic [REG_W-1:0]  req_reg_q, req_reg_d;
    logic [DATA_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

    // MEM/WB output registers
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [REG_W-1:0]  wreg_out_q, wreg_out_d;
    logic              regwrite_out_q, regwrite_out_d;
    logic              memtoreg_out_q, memtoreg_out_d;
    logic              misalign_q, misalign_d;

    logic [DATA_W-1:0] mem_array [DEPTH_WORDS];

    // Operation currently being resolved: live inputs in IDLE, latched copy in BUSY
    logic              cur_write, cur_read, cur_regwrite, cur_memtoreg, cur_signed;
    logic [1:0]        cur_size;
    logic [REG_W-1:0]  cur_reg;
    logic [DATA_W-1:0] cur_addr, cur_wdata;

    logic                 complete_c;
    logic                 stall_c;
    logic                 mis_c;
    logic                 mem_we_c;
    logic [2:0]           offset_c;
    logic [5:0]           shamt_c;
    logic [ADDR_W-1:0]    index_c;
    logic [NUM_BYTES-1:0] be_base_c, byte_en_c;
    logic [DATA_W-1:0]    rd_word_c, rd_shift_c, wr_shift_c, merged_c, ext_c, load_data_c;

    // Select the operation source
    always_comb begin
        if (state_q == S_BUSY) begin
            cur_write    = req_write_q;
            cur_read     = req_read_q;
            cur_regwrite = req_regwrite_q;
            cur_memtoreg = req_memtoreg_q;
            cur_size     = req_size_q;
            cur_signed   = req_signed_q;
            cur_reg      = req_reg_q;
            cur_addr     = req_addr_q;
            cur_wdata    = req_wdata_q;
        end else begin
            cur_write    = MemWrite;
            cur_read     = MemRead;
            cur_regwrite = RegWrite;
            cur_memtoreg = MemtoReg;
            cur_size     = mem_size;
            cur_signed   = mem_signed;
            cur_reg      = WriteReg;
            cur_addr     = ALUResult;
            cur_wdata    = WriteData;
        end
    end

    // Address decode, alignment check, lane merge for stores and load extraction
    always_comb begin
        offset_c  = cur_addr[2:0];
        shamt_c   = {offset_c, 3'b000};
        index_c   = cur_addr[ADDR_W+2:3];
        rd_word_c = mem_array[index_c];

        mis_c     = 1'b0;
        be_base_c = '1;
        case (cur_size)
            2'b00: be_base_c = NUM_BYTES'(1);
            2'b01: begin
                be_base_c = NUM_BYTES'(3);
                mis_c     = offset_c[0];
            end
            2'b10: begin
                be_base_c = NUM_BYTES'(15);
                mis_c     = (offset_c[1:0] != 2'b00);
            end
            default: begin
                be_base_c = '1;
                mis_c     = (offset_c != 3'b000);
            end
        endcase
        if (!(cur_read || cur_write)) begin
            mis_c = 1'b0;
        end
        byte_en_c = be_base_c << offset_c;

        wr_shift_c = cur_wdata << shamt_c;
        merged_c   = rd_word_c;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (byte_en_c[b]) begin
                merged_c[b*8 +: 8] = wr_shift_c[b*8 +: 8];
            end
        end

        rd_shift_c = rd_word_c >> shamt_c;
        case (cur_size)
            2'b00:   ext_c = {{(DATA_W-8){cur_signed & rd_shift_c[7]}}, rd_shift_c[7:0]};
            2'b01:   ext_c = {{(DATA_W-16){cur_signed & rd_shift_c[15]}}, rd_shift_c[15:0]};
            2'b10:   ext_c = {{(DATA_W-32){cur_signed & rd_shift_c[31]}}, rd_shift_c[31:0]};
            default: ext_c = rd_shift_c;
        endcase
        load_data_c = (cur_read && !cur_write && !mis_c) ? ext_c : '0;
    end

    // Next-state, latency counter, request latch and stall request
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_write_d    = req_write_q;
        req_read_d     = req_read_q;
        req_regwrite_d = req_regwrite_q;
        req_memtoreg_d = req_memtoreg_q;
        req_size_d     = req_size_q;
        req_signed_d   = req_signed_q;
        req_reg_d      = req_reg_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        complete_c     = 1'b0;
        stall_c        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if ((MemRead || MemWrite) && MULTI_CYC) begin
                        state_d        = S_BUSY;
                        cnt_d          = CNT_W'(1);
                        stall_c        = 1'b1;
                        req_write_d    = MemWrite;
                        req_read_d     = MemRead;
                        req_regwrite_d = RegWrite;
                        req_memtoreg_d = MemtoReg;
                        req_size_d     = mem_size;
                        req_signed_d   = mem_signed;
                        req_reg_d      = WriteReg;
                        req_addr_d     = ALUResult;
                        req_wdata_d    = WriteData;
                    end else begin
                        complete_c = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(LAST_CNT)) begin
                    complete_c = 1'b1;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    stall_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB bundle loads on completion; out_valid is a single-cycle pulse
    always_comb begin
        out_valid_d    = 1'b0;
        read_data_d    = read_data_q;
        alu_out_d      = alu_out_q;
        wreg_out_d     = wreg_out_q;
        regwrite_out_d = regwrite_out_q;
        memtoreg_out_d = memtoreg_out_q;
        misalign_d     = misalign_q;
        mem_we_c       = complete_c && cur_write && !mis_c;
        if (complete_c) begin
            out_valid_d    = 1'b1;
            read_data_d    = load_data_c;
            alu_out_d      = cur_addr;
            wreg_out_d     = cur_reg;
            regwrite_out_d = cur_regwrite && !mis_c;
            memtoreg_out_d = cur_memtoreg;
            misalign_d     = mis_c;
        end
    end

    // Control, request and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            req_write_q    <= 1'b0;
            req_read_q     <= 1'b0;
            req_regwrite_q <= 1'b0;
            req_memtoreg_q <= 1'b0;
            req_size_q     <= 2'b00;
            req_signed_q   <= 1'b0;
            req_reg_q      <= '0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            out_valid_q    <= 1'b0;
            read_data_q    <= '0;
            alu_out_q      <= '0;
            wreg_out_q     <= '0;
            regwrite_out_q <= 1'b0;
            memtoreg_out_q <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_write_q    <= req_write_d;
            req_read_q     <= req_read_d;
            req_regwrite_q <= req_regwrite_d;
            req_memtoreg_q <= req_memtoreg_d;
            req_size_q     <= req_size_d;
            req_signed_q   <= req_signed_d;
            req_reg_q      <= req_reg_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            out_valid_q    <= out_valid_d;
            read_data_q    <= read_data_d;
            alu_out_q      <= alu_out_d;
            wreg_out_q     <= wreg_out_d;
            regwrite_out_q <= regwrite_out_d;
            memtoreg_out_q <= memtoreg_out_d;
            misalign_q     <= misalign_d;
        end
    end

    // Data memory: full-word write of the lane-merged value at the completion edge
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem_array[index_c] <= merged_c;
        end
    end

    assign stall        = stall_c;
    assign out_valid    = out_valid_q;
    assign ReadData     = read_data_q;
    assign ALUResultout = alu_out_q;
    assign WriteRegout  = wreg_out_q;
    assign RegWriteout  = regwrite_out_q;
    assign MemtoRegout  = memtoreg_out_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe at MEM_LATENCY=3 with a byte-addressed reference memory.
module tb_mem_stage_pipe;

    localparam int unsigned LAT = 3;

    logic        clock, reset_n, in_valid;
    logic        MemWrite, MemRead, RegWrite, MemtoReg, mem_signed;
    logic [1:0]  mem_size;
    logic [4:0]  WriteReg;
    logic [63:0] ALUResult, WriteData;
    logic        stall, out_valid, RegWriteout, MemtoRegout, misalign;
    logic [63:0] ReadData, ALUResultout;
    logic [4:0]  WriteRegout;

    mem_stage_pipe #(
        .DATA_W(64), .REG_W(5), .DEPTH_WORDS(256), .MEM_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .MemWrite(MemWrite), .MemRead(MemRead), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .mem_size(mem_size), .mem_signed(mem_signed), .WriteReg(WriteReg),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .stall(stall), .out_valid(out_valid), .ReadData(ReadData),
        .ALUResultout(ALUResultout), .WriteRegout(WriteRegout),
        .RegWriteout(RegWriteout), .MemtoRegout(MemtoRegout), .misalign(misalign)
    );

    typedef struct {
        logic [63:0] rd;
        logic [63:0] alu;
        logic [4:0]  wreg;
        logic        rw;
        logic        m2r;
        logic        mis;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] bmem [0:2047];
    int         checks   = 0;
    int         failures = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model over a byte array; updates memory for stores
    function automatic exp_t model_op(input logic mw, input logic mr, input logic rw,
                                      input logic m2r, input logic [1:0] sz, input logic sg,
                                      input logic [4:0] wr, input logic [63:0] a,
                                      input logic [63:0] wd);
        exp_t        e;
        int          n;
        logic [63:0] v;
        logic        bad;
        n   = 1 << sz;
        bad = (mw || mr) && ((int'(a[2:0]) % n) != 0);
        v   = '0;
        if (mw && !bad) begin
            for (int i = 0; i < n; i++) bmem[int'(a[10:0]) + i] = wd[8*i +: 8];
        end
        if (mr && !mw && !bad) begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[int'(a[10:0]) + i];
            if (sg && n < 8 && v[8*n-1]) begin
                for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
            end
        end
        e.rd   = v;
        e.alu  = a;
        e.wreg = wr;
        e.rw   = rw && !bad;
        e.m2r  = m2r;
        e.mis  = bad;
        return e;
    endfunction

    // Drive one instruction, hold it while stalled, and count stall cycles
    task automatic issue(input logic mw, input logic mr, input logic [1:0] sz, input logic sg,
                         input logic [4:0] wr, input logic [63:0] a, input logic [63:0] wd,
                         input int exp_stall);
        int   stalls;
        logic s;
        logic done;
        @(negedge clock);
        MemWrite = mw; MemRead = mr; RegWrite = mr || !mw; MemtoReg = mr;
        mem_size = sz; mem_signed = sg; WriteReg = wr; ALUResult = a; WriteData = wd;
        in_valid = 1'b1;
        exp_q.push_back(model_op(mw, mr, mr || !mw, mr, sz, sg, wr, a, wd));
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            s = stall;
            if (s) stalls++;
            @(posedge clock);
            if (!s) done = 1'b1;
            else @(negedge clock);
        end
        if (!done) check("accept_timeout", 64'(done), 64'(1));
        check("stall_cycles", 64'(stalls), 64'(exp_stall));
    endtask

    task automatic drop_valid();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected bundle
    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("ReadData", ReadData, mon_e.rd);
                check("ALUResultout", ALUResultout, mon_e.alu);
                check("WriteRegout", 64'(WriteRegout), 64'(mon_e.wreg));
                check("RegWriteout", 64'(RegWriteout), 64'(mon_e.rw));
                check("MemtoRegout", 64'(MemtoRegout), 64'(mon_e.m2r));
                check("misalign", 64'(misalign), 64'(mon_e.mis));
            end
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) bmem[i] = 8'h00;
        reset_n = 1'b0; in_valid = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        RegWrite = 1'b0; MemtoReg = 1'b0; mem_size = 2'b00; mem_signed = 1'b0;
        WriteReg = '0; ALUResult = '0; WriteData = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_ReadData", ReadData, 64'(0));
        check("rst_ALUResultout", ALUResultout, 64'(0));
        check("rst_RegWriteout", 64'(RegWriteout), 64'(0));
        check("rst_misalign", 64'(misalign), 64'(0));
        reset_n = 1'b1;

        // Known contents for the low 8 words
        for (int w = 0; w < 8; w++)
            issue(1'b1, 1'b0, 2'b11, 1'b0, 5'd0, 64'(w * 8), {$urandom, $urandom}, LAT - 1);

        // Dword store / load
        issue(1'b1, 1'b0, 2'b11, 1'b0, 5'd1, 64'h10, 64'hDEADBEEF_CAFEF00D, LAT - 1);
        issue(1'b0, 1'b1, 2'b11, 1'b0, 5'd2, 64'h10, 64'h0, LAT - 1);

        // Byte store then signed/unsigned byte loads and a full-word readback
        issue(1'b1, 1'b0, 2'b00, 1'b0, 5'd3, 64'h13, 64'h80, LAT - 1);
        issue(1'b0, 1'b1, 2'b00, 1'b1, 5'd4, 64'h13, 64'h0, LAT - 1);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 5'd5, 64'h13, 64'h0, LAT - 1);
        issue(1'b0, 1'b1, 2'b11, 1'b0, 5'd6, 64'h10, 64'h0, LAT - 1);

        // Misaligned half load and half store, memory must stay unchanged
        issue(1'b0, 1'b1, 2'b01, 1'b1, 5'd8, 64'h11, 64'h0, LAT - 1);
        issue(1'b1, 1'b0, 2'b01, 1'b0, 5'd9, 64'h11, 64'hFFFF, LAT - 1);
        issue(1'b0, 1'b1, 2'b11, 1'b0, 5'd10, 64'h10, 64'h0, LAT - 1);

        // Non-memory passthrough: one-cycle latency, no stall
        issue(1'b0, 1'b0, 2'b00, 1'b0, 5'd7, 64'h42, 64'h0, 0);

        // Address wraps modulo the memory depth
        issue(1'b1, 1'b0, 2'b11, 1'b0, 5'd11, 64'h800, 64'h0BAD_F00D_1234_5678, LAT - 1);
        issue(1'b0, 1'b1, 2'b11, 1'b0, 5'd12, 64'h0, 64'h0, LAT - 1);

        // Read and write together: store happens, ReadData is zero
        issue(1'b1, 1'b1, 2'b10, 1'b0, 5'd13, 64'h24, 64'hAAAA_5555_1357_9BDF, LAT - 1);
        issue(1'b0, 1'b1, 2'b11, 1'b0, 5'd14, 64'h20, 64'h0, LAT - 1);

        // Reset during a BUSY store abandons it
        issue(1'b1, 1'b0, 2'b11, 1'b0, 5'd15, 64'h8, 64'h0123_4567_89AB_CDEF, LAT - 1);
        @(negedge clock);
        MemWrite = 1'b1; MemRead = 1'b0; mem_size = 2'b11; ALUResult = 64'h8;
        WriteData = 64'h11; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_mid_stall", 64'(stall), 64'(0));
        for (int c = 0; c < LAT + 1; c++) begin
            @(negedge clock);
            check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        end
        reset_n = 1'b1;
        issue(1'b0, 1'b1, 2'b11, 1'b0, 5'd16, 64'h8, 64'h0, LAT - 1);

        // Randomised mix over the initialised region, back to back
        for (int k = 0; k < 40; k++) begin
            logic mw, mr;
            mw = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            issue(mw, mr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 64'($urandom_range(0, 63)),
                  {$urandom, $urandom}, (mw || mr) ? int'(LAT - 1) : 0);
        end
        drop_valid();

        repeat (LAT + 3) @(negedge clock);
        check("pending_expected", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
